// File: rtl/tick_gen_pkg.sv
// -----------------------------------------------------------------------------
// tick_gen_pkg
// Shared definitions for the multi-channel fractional tick generator:
//   MAX_CHANNELS / MAX_ACC_WIDTH  upper bounds for the top-level parameters
//   cfg_req_t                     one configuration request (channel, inc, imm)
//   calc_inc()                    rate-to-increment conversion, rounded to nearest
// -----------------------------------------------------------------------------
package tick_gen_pkg;

    localparam int MAX_CHANNELS  = 16;
    localparam int MAX_ACC_WIDTH = 32;

    typedef struct packed {
        logic [3:0]               chan;
        logic [MAX_ACC_WIDTH-1:0] inc;
        logic                     imm;
    } cfg_req_t;

    // inc = round(rate * 2^width / clk), computed in 64 bits so the shifted
    // rate cannot overflow for any realistic clock/rate pair.
    function automatic logic [63:0] calc_inc(input logic [63:0] clk_hz,
                                             input logic [63:0] rate_hz,
                                             input int unsigned width);
        return ((rate_hz << width) + (clk_hz >> 1)) / clk_hz;
    endfunction

endpackage

// File: rtl/multi_tick_gen_channel.sv
// -----------------------------------------------------------------------------
// multi_tick_gen_channel
// One phase-accumulator channel: emits a 1-cycle tick each time the fraction
// accumulator overflows, and toggles a square output on every tick.
// Ports:
//   clk_in, rst_in     clock, synchronous active-high reset
//   i_en               accumulate enable
//   i_sync             phase restart (acc and square cleared)
//   i_cfg_we           config write strobe (already qualified by valid&ready)
//   i_cfg_imm          1: apply increment now and clear phase; 0: defer
//   i_cfg_inc          new increment
//   o_tick             registered carry of the accumulator
//   o_square           toggles on every tick
//   o_pending          a deferred increment is waiting to be applied
// -----------------------------------------------------------------------------
module multi_tick_gen_channel
    import tick_gen_pkg::*;
#(
    parameter int                   ACC_WIDTH   = 16,
    parameter logic [ACC_WIDTH-1:0] DEFAULT_INC = '0
) (
    input  logic                 clk_in,
    input  logic                 rst_in,
    input  logic                 i_en,
    input  logic                 i_sync,
    input  logic                 i_cfg_we,
    input  logic                 i_cfg_imm,
    input  logic [ACC_WIDTH-1:0] i_cfg_inc,
    output logic                 o_tick,
    output logic                 o_square,
    output logic                 o_pending
);

    logic [ACC_WIDTH:0]   r_acc;
    logic [ACC_WIDTH-1:0] r_inc;
    logic [ACC_WIDTH-1:0] r_pend_inc;
    logic                 r_pending;
    logic                 r_square;
    logic [ACC_WIDTH:0]   w_sum;

    // The carry bit of r_acc is never fed back: only the fraction accumulates.
    assign w_sum = {1'b0, r_acc[ACC_WIDTH-1:0]} + {1'b0, r_inc};

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            r_acc      <= '0;
            r_inc      <= DEFAULT_INC;
            r_pend_inc <= '0;
            r_pending  <= 1'b0;
            r_square   <= 1'b0;
        end else begin
            if (i_sync) begin
                // Phase restart wins; a waiting deferred increment is kept.
                r_acc    <= '0;
                r_square <= 1'b0;
            end else if (i_cfg_we && i_cfg_imm) begin
                r_inc <= i_cfg_inc;
                r_acc <= '0;
            end else if (i_en) begin
                r_acc <= w_sum;
                if (w_sum[ACC_WIDTH]) begin
                    r_square <= ~r_square;
                end
                // The overflowing add used the old increment; the new one takes
                // over from the next add. A silent channel never carries, so it
                // takes the new value straight away.
                if (r_pending && (w_sum[ACC_WIDTH] || (r_inc == '0))) begin
                    r_inc     <= r_pend_inc;
                    r_pending <= 1'b0;
                end
            end else begin
                r_acc <= {1'b0, r_acc[ACC_WIDTH-1:0]};
                if (r_pending) begin
                    r_inc     <= r_pend_inc;
                    r_pending <= 1'b0;
                end
            end

            // A write is only accepted while nothing is pending, so this never
            // collides with the apply above.
            if (i_cfg_we && !i_cfg_imm) begin
                r_pend_inc <= i_cfg_inc;
                r_pending  <= 1'b1;
            end
        end
    end

    assign o_tick    = r_acc[ACC_WIDTH];
    assign o_square  = r_square;
    assign o_pending = r_pending;

endmodule

// File: rtl/multi_tick_gen.sv
// -----------------------------------------------------------------------------
// multi_tick_gen
// N-channel fractional-rate strobe generator. Each channel ticks at an average
// rate of inc/2^ACC_WIDTH per clock and drives a square wave at half that rate.
// Ports:
//   clk_in, rst_in     clock, synchronous active-high reset
//   en_in[c]           per-channel accumulate enable
//   sync_in[c]         per-channel phase restart pulse
//   cfg_valid_in       config request valid
//   cfg_ready_out      config request can be accepted
//   cfg_chan_in        target channel (out-of-range requests are accepted and dropped)
//   cfg_inc_in         new increment (0 silences the channel)
//   cfg_imm_in         1: apply now and clear phase; 0: apply at the next carry
//   tick_out[c]        1-cycle strobe
//   square_out[c]      toggles on every tick
//
// Handshake: a request transfers on the cycle where cfg_valid_in && cfg_ready_out.
// cfg_ready_out is combinational on cfg_chan_in and is low only while the addressed
// channel holds a deferred increment; it does not depend on cfg_valid_in.
// -----------------------------------------------------------------------------
module multi_tick_gen
    import tick_gen_pkg::*;
#(
    parameter int CHANNELS      = 4,
    parameter int ACC_WIDTH     = 16,
    parameter int CLK_FREQUENCY = 50000000,
    parameter int DEFAULT_RATE  = 115200,
    localparam int CW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
    input  logic                 clk_in,
    input  logic                 rst_in,
    input  logic [CHANNELS-1:0]  en_in,
    input  logic [CHANNELS-1:0]  sync_in,
    input  logic                 cfg_valid_in,
    output logic                 cfg_ready_out,
    input  logic [CW-1:0]        cfg_chan_in,
    input  logic [ACC_WIDTH-1:0] cfg_inc_in,
    input  logic                 cfg_imm_in,
    output logic [CHANNELS-1:0]  tick_out,
    output logic [CHANNELS-1:0]  square_out
);

    localparam logic [63:0] DEFAULT_INC64 =
        calc_inc(64'(CLK_FREQUENCY), 64'(DEFAULT_RATE), ACC_WIDTH);
    localparam logic [ACC_WIDTH-1:0] DEFAULT_INC = DEFAULT_INC64[ACC_WIDTH-1:0];

    if (CHANNELS < 1 || CHANNELS > MAX_CHANNELS) begin : g_bad_channels
        $error("multi_tick_gen: CHANNELS out of range");
    end
    if (ACC_WIDTH < 1 || ACC_WIDTH > MAX_ACC_WIDTH) begin : g_bad_width
        $error("multi_tick_gen: ACC_WIDTH out of range");
    end
    if (DEFAULT_INC64 == 64'd0 || DEFAULT_INC64 >= (64'd1 << ACC_WIDTH)) begin : g_bad_inc
        $error("multi_tick_gen: default increment not representable");
    end

    cfg_req_t            w_req;
    logic                w_ready;
    logic [CHANNELS-1:0] w_pending;
    logic [CHANNELS-1:0] w_we;

    assign w_req = '{chan: 4'(cfg_chan_in),
                     inc:  MAX_ACC_WIDTH'(cfg_inc_in),
                     imm:  cfg_imm_in};

    // Unmatched channel numbers leave ready high so the request is swallowed.
    always_comb begin
        w_ready = 1'b1;
        for (int c = 0; c < CHANNELS; c++) begin
            if (w_req.chan == 4'(c)) begin
                w_ready = !w_pending[c];
            end
        end
    end

    assign cfg_ready_out = w_ready;

    for (genvar g = 0; g < CHANNELS; g++) begin : g_chan
        assign w_we[g] = cfg_valid_in && w_ready && (w_req.chan == 4'(g));

        multi_tick_gen_channel #(
            .ACC_WIDTH   (ACC_WIDTH),
            .DEFAULT_INC (DEFAULT_INC)
        ) u_chan (
            .clk_in    (clk_in),
            .rst_in    (rst_in),
            .i_en      (en_in[g]),
            .i_sync    (sync_in[g]),
            .i_cfg_we  (w_we[g]),
            .i_cfg_imm (w_req.imm),
            .i_cfg_inc (w_req.inc[ACC_WIDTH-1:0]),
            .o_tick    (tick_out[g]),
            .o_square  (square_out[g]),
            .o_pending (w_pending[g])
        );
    end

endmodule
